// File: rtl/fpu_issue_arbiter_if.sv
// Handshake bundle between the two FP instruction requesters, the FPU datapath and the
// response consumer. The arbiter takes the master side.
interface fpu_issue_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_instr;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_instr;
    logic        req1_ready;
    logic [31:0] fpu_instr;
    logic        fpu_issue;
    logic        fpu_complete;
    logic [31:0] fpu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    modport master (
        input  req0_valid, req0_instr, req1_valid, req1_instr,
        input  fpu_complete, fpu_result, rsp_ready,
        output req0_ready, req1_ready, fpu_instr, fpu_issue,
        output rsp_valid, rsp_id, rsp_data, rsp_timeout, busy
    );

    modport slave (
        output req0_valid, req0_instr, req1_valid, req1_instr,
        output fpu_complete, fpu_result, rsp_ready,
        input  req0_ready, req1_ready, fpu_instr, fpu_issue,
        input  rsp_valid, rsp_id, rsp_data, rsp_timeout, busy
    );
endinterface

// File: rtl/fpu_issue_arbiter.sv
// Round-robin arbiter sharing one FPU datapath between two requesters, with one
// outstanding operation, a watchdog on the wait phase and an ID-tagged response.
module fpu_issue_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                       clk,
    input  logic                       rst_l,
    fpu_issue_arbiter_if.master        bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic              last_grant_q;
    logic              id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       fpu_instr_q;
    logic [31:0]       rsp_data_q;
    logic              fpu_issue_q;
    logic              rsp_valid_q;
    logic              rsp_timeout_q;
    logic              busy_q;

    logic              idle;
    logic              grant0;
    logic              grant1;

    // A lone requester always wins; on a contest the one not served last wins.
    always_comb begin
        idle   = (state_q == StIdle);
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    end

    assign bus.req0_ready  = idle & grant0;
    assign bus.req1_ready  = idle & grant1;
    assign bus.fpu_instr   = fpu_instr_q;
    assign bus.fpu_issue   = fpu_issue_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            cnt_q         <= '0;
            fpu_instr_q   <= '0;
            rsp_data_q    <= '0;
            fpu_issue_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            fpu_issue_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant0 | grant1) begin
                        fpu_instr_q <= grant1 ? bus.req1_instr : bus.req0_instr;
                        id_q        <= grant1;
                        fpu_issue_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    // Completion beats a coincident watchdog expiry.
                    if (bus.fpu_complete) begin
                        rsp_data_q    <= bus.fpu_result;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else if (cnt_q == CntLast) begin
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        last_grant_q <= id_q;
                        rsp_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-timestamp model.
module tb_fpu_issue_arbiter;

    localparam int TO = 64;

    logic clk;
    logic rst_l;

    fpu_issue_arbiter_if bi ();

    fpu_issue_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (7)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bi)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Model: an operation is described by its accept cycle and, once known, the cycle
    // its response becomes visible. Everything else is derived from those timestamps.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_acc = 0;
    int          m_resp = -1;
    bit          m_id = 0;
    bit          m_last = 1;
    logic [31:0] m_instr = '0;
    logic [31:0] m_data = '0;
    bit          m_to = 0;

    initial begin
        bit g0, g1, e_rv, in_wait;
        forever begin
            @(negedge clk);
            if (!rst_l) begin
                m_active = 0;
                m_resp   = -1;
                m_last   = 1;
                m_instr  = '0;
                m_id     = 0;
                chk("rst_busy", bi.busy, 0);
                chk("rst_issue", bi.fpu_issue, 0);
                chk("rst_rsp_valid", bi.rsp_valid, 0);
                chk("rst_rsp_id", bi.rsp_id, 0);
                chk("rst_rsp_timeout", bi.rsp_timeout, 0);
                chk("rst_fpu_instr", bi.fpu_instr, 0);
                chk("rst_rsp_data", bi.rsp_data, 0);
            end else begin
                g0 = bi.req0_valid && (!bi.req1_valid || m_last);
                g1 = bi.req1_valid && (!bi.req0_valid || !m_last);
                e_rv = m_active && m_resp >= 0 && cyc >= m_resp;
                in_wait = m_active && cyc >= m_acc + 2 && m_resp < 0;
                chk("m_busy", bi.busy, m_active);
                chk("m_issue", bi.fpu_issue, m_active && cyc == m_acc + 1);
                chk("m_ready0", bi.req0_ready, !m_active && g0);
                chk("m_ready1", bi.req1_ready, !m_active && g1);
                chk("m_fpu_instr", bi.fpu_instr, m_instr);
                chk("m_rsp_valid", bi.rsp_valid, e_rv);
                if (e_rv) begin
                    chk("m_rsp_id", bi.rsp_id, m_id);
                    chk("m_rsp_data", bi.rsp_data, m_data);
                    chk("m_rsp_timeout", bi.rsp_timeout, m_to);
                end
                if (!m_active && (g0 || g1)) begin
                    m_active = 1;
                    m_acc    = cyc;
                    m_resp   = -1;
                    m_id     = g1;
                    m_instr  = g1 ? bi.req1_instr : bi.req0_instr;
                end else if (in_wait && bi.fpu_complete) begin
                    m_resp = cyc + 1;
                    m_data = bi.fpu_result;
                    m_to   = 0;
                end else if (in_wait && cyc - (m_acc + 2) == TO - 1) begin
                    m_resp = cyc + 1;
                    m_data = '0;
                    m_to   = 1;
                end else if (e_rv && bi.rsp_ready) begin
                    m_active = 0;
                    m_last   = m_id;
                end
            end
            cyc++;
        end
    end

    task automatic drv_next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drv_next();
        rst_l = 1'b0;
        drv_next();
        drv_next();
        rst_l = 1'b1;
    endtask

    // Finish whatever is in flight: complete immediately and accept the response.
    task automatic drain();
        bi.fpu_complete = 1'b1;
        bi.rsp_ready    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drv_next();
            at_neg();
            if (!bi.busy) break;
        end
        chk("drain_idle", bi.busy, 0);
        drv_next();
        bi.fpu_complete = 1'b0;
        bi.rsp_ready    = 1'b0;
    endtask

    initial begin
        int grants[$];
        int ids[$];
        int nissue, issue_at, nresp, n;

        rst_l = 1'b1;
        bi.req0_valid = 0; bi.req0_instr = '0;
        bi.req1_valid = 0; bi.req1_instr = '0;
        bi.fpu_complete = 0; bi.fpu_result = '0;
        bi.rsp_ready = 0;
        #1 rst_l = 1'b0;
        at_neg();
        chk("reset_busy", bi.busy, 0);
        chk("reset_rsp_valid", bi.rsp_valid, 0);
        chk("reset_fpu_instr", bi.fpu_instr, 0);
        drv_next();
        rst_l = 1'b1;

        // Single request from port 0.
        drv_next();
        bi.req0_valid = 1; bi.req0_instr = 32'h00B50553;
        at_neg(); chk("t1_ready0", bi.req0_ready, 1);
        drv_next(); bi.req0_valid = 0;
        at_neg(); chk("t1_issue", bi.fpu_issue, 1);
        chk("t1_instr", bi.fpu_instr, 32'h00B50553);
        drv_next();
        drv_next();
        drv_next(); bi.fpu_complete = 1; bi.fpu_result = 32'h40490FDB;
        at_neg(); chk("t1_no_rsp_yet", bi.rsp_valid, 0);
        drv_next(); bi.fpu_complete = 0; bi.rsp_ready = 1;
        at_neg();
        chk("t1_rsp_valid", bi.rsp_valid, 1);
        chk("t1_rsp_id", bi.rsp_id, 0);
        chk("t1_rsp_data", bi.rsp_data, 32'h40490FDB);
        chk("t1_rsp_timeout", bi.rsp_timeout, 0);
        drv_next(); bi.rsp_ready = 0;
        at_neg(); chk("t1_idle", bi.busy, 0);

        // Fairness with both requesters held valid, from reset.
        do_reset();
        bi.req0_valid = 1; bi.req1_valid = 1; bi.rsp_ready = 1;
        nissue = 0; issue_at = -100; nresp = 0;
        for (int k = 0; k < 80 && nresp < 4; k++) begin
            bi.req0_instr = $urandom; bi.req1_instr = $urandom;
            bi.fpu_complete = (k == issue_at + 3);
            bi.fpu_result = $urandom;
            at_neg();
            if (bi.req0_ready) grants.push_back(0);
            if (bi.req1_ready) grants.push_back(1);
            if (bi.fpu_issue) begin nissue++; issue_at = k; end
            if (bi.rsp_valid && bi.rsp_ready) begin ids.push_back(int'(bi.rsp_id)); nresp++; end
            drv_next();
        end
        bi.req0_valid = 0; bi.req1_valid = 0; bi.rsp_ready = 0; bi.fpu_complete = 0;
        chk("t2_grant_count", grants.size(), 4);
        chk("t2_resp_count", ids.size(), 4);
        chk("t2_issue_count", nissue, 4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("t2_grant_order", grants[i], i % 2);
        for (int i = 0; i < ids.size() && i < 4; i++) chk("t2_rsp_id_order", ids[i], i % 2);

        // Watchdog expiry on port 1.
        bi.req1_valid = 1; bi.req1_instr = 32'h12345678;
        at_neg(); chk("t3_ready1", bi.req1_ready, 1);
        drv_next(); bi.req1_valid = 0;
        at_neg(); chk("t3_issue", bi.fpu_issue, 1);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            drv_next(); at_neg();
            if (bi.rsp_valid) begin n = i; break; end
        end
        chk("t3_latency_from_issue", n, TO + 1);
        chk("t3_timeout", bi.rsp_timeout, 1);
        chk("t3_data", bi.rsp_data, 0);
        chk("t3_id", bi.rsp_id, 1);
        drv_next(); bi.rsp_ready = 1;
        at_neg();
        drv_next(); bi.rsp_ready = 0; bi.req0_valid = 1; bi.req0_instr = 32'hCAFEF00D;
        at_neg(); chk("t3_new_grant", bi.req0_ready, 1);

        // Completion on the same cycle the watchdog would expire.
        drv_next(); bi.req0_valid = 0;
        at_neg(); chk("t4_issue", bi.fpu_issue, 1);
        for (int i = 0; i < TO; i++) drv_next();
        bi.fpu_complete = 1; bi.fpu_result = 32'h3F800000;
        at_neg(); chk("t4_no_rsp_yet", bi.rsp_valid, 0);
        drv_next(); bi.fpu_complete = 0;
        at_neg();
        chk("t4_rsp_valid", bi.rsp_valid, 1);
        chk("t4_timeout", bi.rsp_timeout, 0);
        chk("t4_data", bi.rsp_data, 32'h3F800000);

        // Back-pressure on the response while port 1 waits.
        bi.req1_valid = 1; bi.req1_instr = 32'h0BADBEEF;
        for (int i = 0; i < 10; i++) begin
            drv_next(); at_neg();
            chk("t5_hold_valid", bi.rsp_valid, 1);
            chk("t5_hold_id", bi.rsp_id, 0);
            chk("t5_hold_data", bi.rsp_data, 32'h3F800000);
            chk("t5_no_ready1", bi.req1_ready, 0);
        end
        drv_next(); bi.rsp_ready = 1;
        at_neg(); chk("t5_handshake_no_ready1", bi.req1_ready, 0);
        drv_next(); bi.rsp_ready = 0;
        at_neg(); chk("t5_accept_after", bi.req1_ready, 1);
        drv_next(); bi.req1_valid = 0;
        drain();

        // Asynchronous reset while waiting on the datapath.
        bi.req0_valid = 1; bi.req0_instr = 32'h55AA55AA;
        at_neg(); chk("t6_ready0", bi.req0_ready, 1);
        drv_next(); bi.req0_valid = 0;
        drv_next();
        #2;
        chk("t6_busy_before", bi.busy, 1);
        rst_l = 1'b0;
        #1;
        chk("t6_busy", bi.busy, 0);
        chk("t6_fpu_instr", bi.fpu_instr, 0);
        chk("t6_issue", bi.fpu_issue, 0);
        chk("t6_rsp_valid", bi.rsp_valid, 0);
        chk("t6_rsp_id", bi.rsp_id, 0);
        chk("t6_rsp_data", bi.rsp_data, 0);
        chk("t6_rsp_timeout", bi.rsp_timeout, 0);
        drv_next(); drv_next();
        rst_l = 1'b1;
        bi.fpu_complete = 1; bi.rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            at_neg(); chk("t6_no_rsp", bi.rsp_valid, 0);
            drv_next();
        end
        bi.fpu_complete = 0; bi.rsp_ready = 0;
        bi.req0_valid = 1; bi.req1_valid = 1;
        at_neg();
        chk("t6_first_contest_0", bi.req0_ready, 1);
        chk("t6_first_contest_1", bi.req1_ready, 0);
        drv_next(); bi.req0_valid = 0; bi.req1_valid = 0;
        drain();

        // Randomized traffic, checked by the model each cycle.
        for (int k = 0; k < 3000; k++) begin
            int pc;
            pc = ((k / 500) % 2 == 0) ? 40 : 1;
            bi.req0_valid   = ($urandom_range(0, 99) < 50);
            bi.req1_valid   = ($urandom_range(0, 99) < 50);
            bi.req0_instr   = $urandom;
            bi.req1_instr   = $urandom;
            bi.fpu_complete = ($urandom_range(0, 99) < pc);
            bi.fpu_result   = $urandom;
            bi.rsp_ready    = ($urandom_range(0, 99) < 60);
            drv_next();
        end
        bi.req0_valid = 0; bi.req1_valid = 0;
        drain();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_arbiter.md
Name: fpu_issue_arbiter

Overview:
Shares the single FPU execution datapath between two instruction requesters: port 0 is the UART-loaded program sequencer and port 1 is a direct host-issue port. The block round-robin arbitrates between them and issues one FP instruction at a time. It holds the instruction stable while the datapath runs, with a watchdog timeout, and routes the 32-bit result back tagged with the requester ID. It sits between the instruction fetch/FSM path and the FPU decode/execution unit.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before an issued operation is abandoned (minimum 2)
CNT_W, 7, width of watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst_l  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an instruction
req0_instr  input  32  requester 0 instruction word
req0_ready  output  1  requester 0 instruction accepted this cycle
req1_valid  input  1  requester 1 has an instruction
req1_instr  input  32  requester 1 instruction word
req1_ready  output  1  requester 1 instruction accepted this cycle
fpu_instr  output  32  instruction presented to FPU decode
fpu_issue  output  1  one-cycle start pulse to FPU
fpu_complete  input  1  FPU operation done, result valid this cycle
fpu_result  input  32  FPU result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that owns the response
rsp_data  output  32  result, or 0 on timeout
rsp_timeout  output  1  response is a watchdog abort
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_l=0): state=IDLE; fpu_instr, rsp_data=0; fpu_issue, rsp_valid, rsp_id, rsp_timeout, busy=0; counter=0; last_grant=1, so req0 wins the first contest.
- Reset mid-operation: the in-flight op is dropped; no response is produced; requesters must re-present.
- Grant logic (combinational, IDLE only):
  - One valid requester: it is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & grantN.
  - Transfer = valid & ready. Ready is never asserted outside IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: on transfer, latch instr into fpu_instr and latch the requester ID. Go to ISSUE. Otherwise stay.
  - ISSUE: fpu_issue=1 for exactly this cycle; clear the counter; go to WAIT.
  - WAIT: the counter increments each cycle.
    - fpu_complete=1: rsp_data<=fpu_result, rsp_timeout<=0, go to RESP.
    - Else if counter==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_timeout<=1, go to RESP.
    - If complete and expiry coincide, complete wins.
  - RESP: rsp_valid=1. rsp_id, rsp_data and rsp_timeout are held stable until rsp_ready. On rsp_valid&rsp_ready: last_grant<=latched ID, rsp_valid<=0, go to IDLE.
- fpu_instr holds its value from ISSUE through RESP and keeps its last value in IDLE.
- fpu_complete is ignored outside WAIT (no state change, no response).
- Latency:
  - Accept at cycle T, fpu_issue at T+1, earliest complete sampled at T+2, rsp_valid at T+3.
  - Back-to-back: a response handshake at cycle R allows a new accept at R+1.
- Throughput: one outstanding operation; no queuing.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- Counter saturates; it is never observed to wrap because exit occurs at TIMEOUT_CYCLES-1.

Test Plan:
- Reset then req0 only, instr 0x00B50553: req0_ready at T, fpu_issue pulse at T+1. Complete at T+4 with 0x40490FDB gives rsp_valid at T+5 with rsp_id=0, rsp_data=0x40490FDB, rsp_timeout=0.
- Both requesters held valid for 4 operations, rsp_ready=1, complete 3 cycles after each issue: grant order 0,1,0,1. rsp_id follows the same order. fpu_issue pulses exactly 4 times.
- No fpu_complete after issue, TIMEOUT_CYCLES=64: rsp_valid exactly 64 cycles after the WAIT entry cycle, with rsp_timeout=1 and rsp_data=0. Then a new grant is possible.
- fpu_complete on the same cycle the counter reaches 63: rsp_timeout=0 and rsp_data equals fpu_result.
- rsp_ready held low for 10 cycles in RESP: rsp_valid, rsp_id and rsp_data stay stable. req1_ready stays 0 even with req1_valid=1. Accept occurs the cycle after the handshake.
- rst_l asserted low in WAIT, asynchronously mid-cycle: all outputs 0 immediately. After release no rsp_valid appears, and req0 is granted first on a contest.
